// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the two requester ports, the RAM port and the busy flag of
//   dmem_port_arbiter.
//   slave  : arbiter view (requests and RAM read data in; grants, responses
//            and RAM controls out).
//   master : requester/RAM-environment view (the mirror of slave).
//   Signals: req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  (requests)
//            gnt0/gnt1, rvalid0/rvalid1, err0/err1, rdata0/rdata1 (responses)
//            mem_we, mem_addr, mem_wdata, mem_rdata          (RAM port)
//            busy                                             (status)
interface dmem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [DATA_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;

  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic                  err0;
  logic                  err1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
    output mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
    input  mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Two-requester arbiter/sequencer for a single-port synchronous data RAM
//   (combinational read, write on the rising clock edge). Requester 0 is the
//   CPU load/store port, requester 1 the loader/debug port. One access is
//   handled at a time through IDLE -> ACCESS -> RESP; the address is range
//   and alignment checked, read data is registered per requester and the
//   completion is signalled with rvalidN qualified by errN.
//
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-low reset
//     bus    : dmem_port_arbiter_if.slave (requests, responses, RAM port, busy)
//
//   Build option:
//     DMEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are
//     resolved by a round-robin pointer; otherwise requester 0 always wins.
module dmem_port_arbiter #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Upper bound is formed one bit wider so BASE + 4*DEPTH cannot wrap.
  localparam logic [DATA_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [DATA_WIDTH:0] SPAN      = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);
  localparam logic [DATA_WIDTH:0] LIMIT_EXT = BASE_EXT + SPAN;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q,    we_d;
  logic [DATA_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  any_req;
  logic                  sel_win;
  logic                  in_range;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Holds the requester preferred on the next simultaneous request.
  logic                  prio_q, prio_d;
`endif

  // Winner selection for the current request set.
  always_comb begin
    any_req = bus.req0 || bus.req1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    sel_win = (bus.req0 && bus.req1) ? prio_q : bus.req1;
`else
    sel_win = !bus.req0;
`endif
  end

  // Range and alignment check on the latched address.
  always_comb begin
    in_range = ({1'b0, addr_q} >= BASE_EXT) &&
               ({1'b0, addr_q} <  LIMIT_EXT) &&
               (addr_q[1:0] == 2'b00);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    prio_d   = prio_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = sel_win;
          we_d    = sel_win ? bus.we1    : bus.we0;
          addr_d  = sel_win ? bus.addr1  : bus.addr0;
          wdata_d = sel_win ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          prio_d  = !sel_win;
`endif
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Only successful reads update the owner's read-data register.
        if (!we_q && in_range) begin
          if (owner_q) begin
            rdata1_d = bus.mem_rdata;
          end else begin
            rdata0_d = bus.mem_rdata;
          end
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      prio_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      prio_q   <= prio_d;
`endif
    end
  end

  // Outputs decoded from the registered state; gnt/rvalid/err belong only
  // to the latched owner.
  always_comb begin
    bus.gnt0    = (state_q == ST_ACCESS) && !owner_q;
    bus.gnt1    = (state_q == ST_ACCESS) &&  owner_q;
    bus.rvalid0 = (state_q == ST_RESP)   && !owner_q;
    bus.rvalid1 = (state_q == ST_RESP)   &&  owner_q;
    bus.err0    = bus.rvalid0 && !in_range;
    bus.err1    = bus.rvalid1 && !in_range;
    bus.rdata0  = rdata0_q;
    bus.rdata1  = rdata1_q;
    bus.busy    = (state_q != ST_IDLE);
  end

  // RAM port: parked at BASE_ADDR outside ACCESS. The write enable is gated
  // by reset so an access abandoned by reset never commits.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = BASE_ADDR;
    bus.mem_wdata = '0;
    if (state_q == ST_ACCESS) begin
      bus.mem_we    = we_q && in_range && reset;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Bench for dmem_port_arbiter: a behavioural RAM, a table of directed
//   single transactions, hand-written multi-cycle sequences (simultaneous
//   requests, reset mid-access, held request) and random transactions
//   checked against a transaction-level memory model.
module tb_dmem_port_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dmem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

  dmem_port_arbiter #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(64),
    .BASE_ADDR   (32'h1001_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM.
  logic [31:0] ram [DEPTH];
  logic [5:0]  ram_idx;
  assign ram_idx       = bus.mem_addr[7:2];
  assign bus.mem_rdata = ram[ram_idx];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[ram_idx] <= bus.mem_wdata;
  end

  // Transaction-level reference model.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] mdl_rdata [2];
  bit          mdl_pref;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          who;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned av = longint'(a);
    return (av >= longint'(BASE)) && (av < longint'(BASE) + 4 * DEPTH) && (av % 4 == 0);
  endfunction

  task automatic model_txn(input bit who, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output bit exp_err,
                           output logic [31:0] exp_rd);
    int idx;
    exp_err = !addr_ok(addr);
    idx = int'((longint'(addr) - longint'(BASE)) / 4);
    if (!exp_err) begin
      if (we) ref_mem[idx] = wdata;
      else    mdl_rdata[who] = ref_mem[idx];
    end
    exp_rd = mdl_rdata[who];
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
  endtask

  task automatic drive(input bit who, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    idle_inputs();
    if (who) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  // One complete access starting from IDLE; ends in IDLE.
  task automatic transact(input bit who, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_err,
                          input logic [31:0] exp_rd, input string tag);
    logic [31:0] onehot;
    onehot = who ? 32'd2 : 32'd1;
    drive(who, we, addr, wdata);
    tick();
    chk({tag, ".gnt"},       {30'd0, bus.gnt1, bus.gnt0}, onehot);
    chk({tag, ".mem_we"},    {31'd0, bus.mem_we}, {31'd0, we && !exp_err});
    chk({tag, ".mem_addr"},  bus.mem_addr, addr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, wdata);
    // Request dropped and inputs scrambled: the access must use latched values.
    idle_inputs();
    bus.addr0 = $urandom; bus.addr1 = $urandom;
    bus.wdata0 = $urandom; bus.wdata1 = $urandom;
    tick();
    chk({tag, ".rvalid"}, {30'd0, bus.rvalid1, bus.rvalid0}, onehot);
    chk({tag, ".err"},    {30'd0, bus.err1, bus.err0}, exp_err ? onehot : 32'd0);
    chk({tag, ".rdata"},  who ? bus.rdata1 : bus.rdata0, exp_rd);
    tick();
    chk({tag, ".busy"},   {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst.gnt",    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("rst.rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("rst.err",    {30'd0, bus.err1, bus.err0}, 32'd0);
    chk("rst.busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst.rdata0", bus.rdata0, 32'd0);
    chk("rst.rdata1", bus.rdata1, 32'd0);
    chk("rst.mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst.mem_addr", bus.mem_addr, BASE);
    chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b1;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    mdl_pref = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          e;
    logic [31:0] rd;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    idle_inputs();

    // who, we, addr, wdata, exp_err, exp_rdata (of that requester afterwards)
    vecs[0]  = '{0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 0, 32'h0000_0000};
    vecs[1]  = '{0, 0, 32'h1001_0008, 32'h0000_0000, 0, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 1, 32'h1001_0100, 32'h1111_1111, 1, 32'h0000_0000};
    vecs[3]  = '{1, 1, 32'h1000_FFFC, 32'h2222_2222, 1, 32'h0000_0000};
    vecs[4]  = '{0, 1, 32'h1001_0000, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF};
    vecs[5]  = '{0, 1, 32'h1001_0002, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF};
    vecs[6]  = '{0, 0, 32'h1001_0000, 32'h0000_0000, 0, 32'hA5A5_A5A5};
    vecs[7]  = '{1, 1, 32'h1001_00FC, 32'hCAFE_F00D, 0, 32'h0000_0000};
    vecs[8]  = '{1, 0, 32'h1001_00FC, 32'h0000_0000, 0, 32'hCAFE_F00D};
    vecs[9]  = '{1, 0, 32'h1001_0100, 32'h0000_0000, 1, 32'hCAFE_F00D};
    vecs[10] = '{1, 0, 32'h1001_00FD, 32'h0000_0000, 1, 32'hCAFE_F00D};
    vecs[11] = '{1, 0, 32'h1000_FFFC, 32'h0000_0000, 1, 32'hCAFE_F00D};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      model_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, e, rd);
      transact(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_err, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    // Simultaneous held requests for four transactions.
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h1001_0008;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h1001_00FC;
    for (int t = 0; t < 4; t++) begin
      bit win;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      win = mdl_pref;
      mdl_pref = !win;
`else
      win = 1'b0;
`endif
      model_txn(win, 1'b0, win ? 32'h1001_00FC : 32'h1001_0008, 32'd0, e, rd);
      tick();
      chk($sformatf("simul%0d.gnt", t), {30'd0, bus.gnt1, bus.gnt0}, win ? 32'd2 : 32'd1);
      if (t == 3) idle_inputs();
      tick();
      chk($sformatf("simul%0d.rvalid", t), {30'd0, bus.rvalid1, bus.rvalid0}, win ? 32'd2 : 32'd1);
      chk($sformatf("simul%0d.rdata", t), win ? bus.rdata1 : bus.rdata0, rd);
      tick();
    end
    chk("simul.busy", {31'd0, bus.busy}, 32'd0);

    // Reset during the ACCESS cycle of a write.
    model_txn(0, 1'b1, 32'h1001_0010, 32'h0BAD_F00D, e, rd);
    transact(0, 1'b1, 32'h1001_0010, 32'h0BAD_F00D, e, rd, "pre");
    drive(0, 1'b1, 32'h1001_0010, 32'h1234_5678);
    tick();
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("midrst.mem_we", {31'd0, bus.mem_we}, 32'd0);
    tick();
    chk("midrst.busy",   {31'd0, bus.busy}, 32'd0);
    chk("midrst.rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("midrst.err",    {30'd0, bus.err1, bus.err0}, 32'd0);
    reset = 1'b1;
    mdl_rdata[0] = '0; mdl_rdata[1] = '0; mdl_pref = 1'b0;
    tick();
    chk("midrst.rvalid2", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    model_txn(0, 1'b0, 32'h1001_0010, 32'd0, e, rd);
    transact(0, 1'b0, 32'h1001_0010, 32'd0, e, rd, "postrst");

    // req0 held for six cycles, address changed after each grant.
    drive(0, 1'b1, 32'h1001_0020, 32'h1111_0001);
    tick();
    chk("held.gnt_c1",  {31'd0, bus.gnt0}, 32'd1);
    chk("held.addr_c1", bus.mem_addr, 32'h1001_0020);
    bus.addr0 = 32'h1001_0024; bus.wdata0 = 32'h2222_0002;
    tick();
    chk("held.rvalid_c2", {31'd0, bus.rvalid0}, 32'd1);
    tick();
    chk("held.busy_c3", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("held.gnt_c4",   {31'd0, bus.gnt0}, 32'd1);
    chk("held.addr_c4",  bus.mem_addr, 32'h1001_0024);
    chk("held.wdata_c4", bus.mem_wdata, 32'h2222_0002);
    bus.addr0 = 32'h1001_002C; bus.wdata0 = 32'h3333_0003;
    tick();
    chk("held.rvalid_c5", {31'd0, bus.rvalid0}, 32'd1);
    idle_inputs();
    tick();
    chk("held.busy_c6", {31'd0, bus.busy}, 32'd0);
    model_txn(0, 1'b1, 32'h1001_0020, 32'h1111_0001, e, rd);
    model_txn(0, 1'b1, 32'h1001_0024, 32'h2222_0002, e, rd);
    model_txn(1, 1'b0, 32'h1001_0020, 32'd0, e, rd);
    transact(1, 1'b0, 32'h1001_0020, 32'd0, e, rd, "held_rd0");
    model_txn(1, 1'b0, 32'h1001_0024, 32'd0, e, rd);
    transact(1, 1'b0, 32'h1001_0024, 32'd0, e, rd, "held_rd1");
    model_txn(1, 1'b0, 32'h1001_0028, 32'd0, e, rd);
    transact(1, 1'b0, 32'h1001_0028, 32'd0, e, rd, "held_rd2");

    // Random single-requester transactions against the model.
    for (int n = 0; n < 60; n++) begin
      bit who, we;
      logic [31:0] wd;
      int k;
      who = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      k   = int'($urandom_range(0, 5));
      case (k)
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        3:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        4:       a = BASE - 32'(4 * $urandom_range(1, 4));
        default: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      endcase
      model_txn(who, we, a, wd, e, rd);
      transact(who, we, a, wd, e, rd, $sformatf("rand%0d", n));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
